// File: rtl/relu.sv
// Registered ReLU on a sample split into signed upper and unsigned lower slices,
// with a saturating count of samples that were zeroed because they were negative.
module relu #(
    parameter int MSB_W = 6,
    parameter int LSB_W = 12,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MSB_W-1:0]       dout_msb,
    input  logic [LSB_W-1:0]       dout_lsb,
    input  logic                   in_valid,
    output logic [MSB_W+LSB_W-1:0] dout_relu,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       neg_count
);

    localparam int W = MSB_W + LSB_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0] sample;
    logic         is_neg;

    assign sample = {dout_msb, dout_lsb};
    assign is_neg = dout_msb[MSB_W-1];

    // Handshake: in_valid marks a sample for one cycle and there is no ready,
    // so every valid sample is taken; out_valid pulses exactly one cycle later
    // alongside its result, and dout_relu holds its value while out_valid is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_relu <= '0;
            out_valid <= 1'b0;
            neg_count <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dout_relu <= is_neg ? '0 : sample;
                if (is_neg && (neg_count != CNT_MAX)) begin
                    neg_count <= neg_count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_relu.sv
// Randomized self-checking bench for relu: a signed-arithmetic reference model
// feeds an expected-result queue that each DUT output is scored against.
module tb_relu;

    localparam int MSB_W = 6;
    localparam int LSB_W = 12;
    localparam int CNT_W = 5;
    localparam int W = MSB_W + LSB_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [MSB_W-1:0] dout_msb;
    logic [LSB_W-1:0] dout_lsb;
    logic             in_valid;
    logic [W-1:0]     dout_relu;
    logic             out_valid;
    logic [CNT_W-1:0] neg_count;

    relu #(.MSB_W(MSB_W), .LSB_W(LSB_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .dout_msb  (dout_msb),
        .dout_lsb  (dout_lsb),
        .in_valid  (in_valid),
        .dout_relu (dout_relu),
        .out_valid (out_valid),
        .neg_count (neg_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hold;
    int           m_cnt;
    int           n_checks;
    int           n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: value of the sample as a signed number, clipped below at zero.
    task automatic model_accept(input logic [MSB_W-1:0] m, input logic [LSB_W-1:0] l);
        logic signed [W-1:0] x;
        logic [W-1:0]        res;
        x = {m, l};
        if (x < 0) begin
            res = '0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            res = x;
        end
        exp_q.push_back(res);
        m_hold = res;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_hold = '0;
        m_cnt  = 0;
    endtask

    // driver: present one cycle of input, then score the registered outputs
    task automatic drive(input logic v, input logic [MSB_W-1:0] m, input logic [LSB_W-1:0] l);
        logic [W-1:0] exp;
        @(negedge clk);
        in_valid = v;
        dout_msb = m;
        dout_lsb = l;
        @(posedge clk);
        if (v) model_accept(m, l);
        #1;
        check("out_valid", out_valid, v);
        if (v) begin
            exp = exp_q.pop_front();
            check("dout_relu", dout_relu, exp);
        end else begin
            check("dout_relu_hold", dout_relu, m_hold);
        end
        check("neg_count", neg_count, m_cnt);
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_dout_relu"}, dout_relu, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_neg_count"}, neg_count, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        dout_msb = '0;
        dout_lsb = '0;

        // reset state, including a valid sample offered while held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        dout_msb = 6'b000001;
        dout_lsb = 12'h001;
        @(posedge clk);
        #1;
        check_zeroed("reset");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // directed positives
        drive(1'b1, 6'b000001, 12'h001);
        check("pos_small", dout_relu, 18'h01001);
        drive(1'b1, 6'b000001, 12'hFFF);
        check("pos_lsb_full", dout_relu, 18'h01FFF);
        drive(1'b1, 6'b011111, 12'hFFF);
        check("pos_max", dout_relu, 18'h1FFFF);

        // directed negatives: zeroed, counter steps 1, 2, 3
        drive(1'b1, 6'b100001, 12'h001);
        check("neg_1", neg_count, 1);
        drive(1'b1, 6'b111111, 12'hFFF);
        check("neg_2", neg_count, 2);
        drive(1'b1, 6'b100000, 12'h001);
        check("neg_3", neg_count, 3);
        check("neg_zeroed", dout_relu, 0);

        // zero input
        drive(1'b1, 6'b000000, 12'h000);
        check("zero_cnt", neg_count, 3);

        // four back-to-back samples then two idle cycles
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'($urandom_range(0, 31)), 12'($urandom));
        end
        drive(1'b0, 6'($urandom), 12'($urandom));
        drive(1'b0, 6'($urandom), 12'($urandom));

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 6'($urandom), 12'($urandom));
        end

        // asynchronous reset between edges while a stream is in flight
        drive(1'b1, 6'b010101, 12'hABC);
        @(negedge clk);
        in_valid = 1'b1;
        dout_msb = 6'b000111;
        dout_lsb = 12'h123;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_zeroed("async_rst");
        @(posedge clk);
        #1;
        check_zeroed("rst_held");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        drive(1'b1, 6'b000001, 12'h001);
        check("post_rst", dout_relu, 18'h01001);

        // saturation of the negative-sample counter
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            drive(1'b1, 6'($urandom_range(32, 63)), 12'($urandom));
        end
        check("sat_value", neg_count, CNT_MAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/relu.md
RELU -- requirements
Module: relu

Interface
- REQ-001: Parameter MSB_W, default 6, width of the upper input slice.
- REQ-002: Parameter LSB_W, default 12, width of the lower input slice.
- REQ-003: Parameter CNT_W, default 16, width of the negative-sample counter.
- REQ-004: Design SHALL use one clock; reset SHALL be asynchronous and active-high.
- REQ-005: clk, input, 1, rising-edge clock for all state.
- REQ-006: rst, input, 1, asynchronous active-high reset.
- REQ-007: dout_msb, input, MSB_W, upper slice of the signed sample; bit MSB_W-1 is the sign bit.
- REQ-008: dout_lsb, input, LSB_W, lower slice of the sample, unsigned bits.
- REQ-009: in_valid, input, 1, sample on dout_msb/dout_lsb is valid this cycle.
- REQ-010: dout_relu, output, MSB_W+LSB_W (18), registered ReLU result.
- REQ-011: out_valid, output, 1, dout_relu holds a new result this cycle.
- REQ-012: neg_count, output, CNT_W, count of accepted samples zeroed by ReLU.

Function
- REQ-013: Sample x SHALL be formed as the two's-complement value {dout_msb, dout_lsb} of MSB_W+LSB_W bits.
- REQ-014: If dout_msb[MSB_W-1] = 1 (x < 0), the result SHALL be all zeros.
- REQ-015: If dout_msb[MSB_W-1] = 0 (x >= 0), the result SHALL equal {dout_msb, dout_lsb} bit-for-bit.
- REQ-016: Only the sign bit decides; the value of dout_lsb SHALL never affect the zeroing decision.
- REQ-017: Zero input SHALL produce zero output, and SHALL NOT increment neg_count.
- REQ-018: Latency SHALL be exactly 1 clock: a sample accepted with in_valid=1 at edge N appears on dout_relu with out_valid=1 after edge N.
- REQ-019: out_valid SHALL be the in_valid registered one cycle; no back-pressure, every valid sample is accepted.
- REQ-020: When in_valid=0, dout_relu SHALL hold its previous value and out_valid SHALL be 0.
- REQ-021: Back-to-back valid samples SHALL produce back-to-back results at full throughput (one per clock).
- REQ-022: neg_count SHALL increment by 1 on each accepted sample with the sign bit set.
- REQ-023: neg_count SHALL saturate at 2^CNT_W-1 (no wrap-around).
- REQ-024: No combinational path SHALL exist from inputs to outputs.

Reset
- REQ-025: While rst=1, dout_relu SHALL be 0, out_valid SHALL be 0, and neg_count SHALL be 0, regardless of clk.
- REQ-026: Reset asserted mid-stream SHALL immediately discard the in-flight result; the first sample accepted after rst deasserts SHALL be processed normally with 1-cycle latency.
- REQ-027: A sample presented in the same cycle that rst deasserts SHALL NOT be accepted; acceptance starts on the first rising edge with rst=0.

Verification
- REQ-028: msb=000001, lsb=000000000001, in_valid=1 -> next cycle dout_relu=0x01001, out_valid=1.
- REQ-029: msb=000001, lsb=111111111111 -> dout_relu=0x01FFF; msb=011111, lsb=FFF -> dout_relu=0x1FFFF (max positive).
- REQ-030: msb=100001, lsb=000000000001; msb=111111, lsb=FFF; msb=100000, lsb=001 -> dout_relu=0 each, neg_count increments 1, 2, 3.
- REQ-031: msb=000000, lsb=000 -> dout_relu=0, neg_count unchanged.
- REQ-032: Stream 4 valid samples then in_valid=0 for 2 cycles -> 4 consecutive out_valid pulses, dout_relu holds last value, out_valid=0 afterwards.
- REQ-033: Assert rst asynchronously between edges during a stream -> dout_relu=0, out_valid=0, neg_count=0 immediately; after release, msb=000001, lsb=001 -> 0x01001 after one clock.
